// File: rtl/sa_sdp_ew_alu_pipe.sv
// ---------------------------------------------------------------------------
// sa_sdp_ew_alu_pipe
//
// Elementwise ALU stage that sits after the SDP two-channel sync stage. Each
// accepted beat carries two signed operands and the op selected at accept
// time. The result is clamped to DATA_WIDTH and passes through two registered
// stages with full valid/ready backpressure. Clamped results are counted for
// the status register.
//
// Pipeline:
//   S1 : operand/op registers (s1_a, s1_b, s1_op, s1_vld)
//   S2 : result register      (s2_data, s2_vld) -> data_out / out_pvld
//
// Ports:
//   autosa_core_clk  in   1           clock, all state on the rising edge
//   autosa_core_rst  in   1           synchronous active-high reset
//   cfg_op           in   2           0=BYPASS 1=ADD 2=MAX 3=MUL, taken per beat
//   cfg_sat_clr      in   1           pulse that clears sat_cnt
//   in_pvld          in   1           input beat valid
//   in_prdy          out  1           input beat ready
//   data1_in         in   DATA_WIDTH  operand A (signed)
//   data2_in         in   DATA_WIDTH  operand B (signed)
//   out_pvld         out  1           result valid
//   out_prdy         in   1           downstream ready
//   data_out         out  DATA_WIDTH  clamped result (signed)
//   sat_cnt          out  CNT_WIDTH   clamped-result count, sticks at all-ones
//   busy             out  1           any stage holds a beat
// ---------------------------------------------------------------------------
module sa_sdp_ew_alu_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  autosa_core_clk,
  input  logic                  autosa_core_rst,
  input  logic [1:0]            cfg_op,
  input  logic                  cfg_sat_clr,
  input  logic                  in_pvld,
  output logic                  in_prdy,
  input  logic [DATA_WIDTH-1:0] data1_in,
  input  logic [DATA_WIDTH-1:0] data2_in,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  sat_cnt,
  output logic                  busy
);

  localparam logic [1:0] OP_BYPASS = 2'd0;
  localparam logic [1:0] OP_ADD    = 2'd1;
  localparam logic [1:0] OP_MAX    = 2'd2;
  localparam logic [1:0] OP_MUL    = 2'd3;

  localparam int PW = 2 * DATA_WIDTH;

  // Clamp bounds expressed at the wide working width.
  localparam logic signed [PW-1:0] WIDE_MAX =
    {{(DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] WIDE_MIN =
    {{(DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [DATA_WIDTH-1:0] RES_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] RES_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Stage registers
  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_a;
  logic [DATA_WIDTH-1:0] s1_b;
  logic [1:0]            s1_op;
  logic                  s2_vld;
  logic [DATA_WIDTH-1:0] s2_data;

  // Handshake terms
  logic s2_rdy;
  logic s1_rdy;
  logic in_fire;
  logic s1_move;
  logic out_fire;

  assign s2_rdy   = !s2_vld || out_prdy;
  assign s1_rdy   = !s1_vld || s2_rdy;
  assign in_prdy  = s1_rdy && !autosa_core_rst;
  assign in_fire  = in_pvld && in_prdy;
  assign s1_move  = s1_vld && s2_rdy;
  assign out_fire = s2_vld && out_prdy;

  assign out_pvld = s2_vld;
  assign data_out = s2_data;
  assign busy     = s1_vld || s2_vld;

  // Arithmetic on the S1 operands, evaluated at twice the data width so that
  // neither the sum nor the full product can overflow before clamping.
  logic signed [PW-1:0]  a_wide;
  logic signed [PW-1:0]  b_wide;
  logic signed [PW-1:0]  res_wide;
  logic [DATA_WIDTH-1:0] s1_res;
  logic                  s1_sat;

  // NOTE: every signal written here gets a default on entry so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    a_wide   = {{DATA_WIDTH{s1_a[DATA_WIDTH-1]}}, s1_a};
    b_wide   = {{DATA_WIDTH{s1_b[DATA_WIDTH-1]}}, s1_b};
    res_wide = a_wide;
    s1_res   = s1_a;
    s1_sat   = 1'b0;

    case (s1_op)
      OP_BYPASS: res_wide = a_wide;
      OP_ADD:    res_wide = a_wide + b_wide;
      OP_MAX:    res_wide = (a_wide >= b_wide) ? a_wide : b_wide;  // tie returns a
      OP_MUL:    res_wide = a_wide * b_wide;
      default:   res_wide = a_wide;
    endcase

    if (res_wide > WIDE_MAX) begin
      s1_res = RES_MAX;
      s1_sat = 1'b1;
    end else if (res_wide < WIDE_MIN) begin
      s1_res = RES_MIN;
      s1_sat = 1'b1;
    end else begin
      s1_res = res_wide[DATA_WIDTH-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, matching real flop behaviour.
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      // NOTE: data registers are reset as well as the valids, so data_out reads
      // zero after reset rather than whatever the last beat left behind.
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_op   <= OP_BYPASS;
      s2_vld  <= 1'b0;
      s2_data <= '0;
      sat_cnt <= '0;
    end else begin
      // S1: load on accept; otherwise empties when its beat moves on.
      if (in_fire) begin
        s1_a   <= data1_in;
        s1_b   <= data2_in;
        s1_op  <= cfg_op;
        s1_vld <= 1'b1;
      end else if (s1_move) begin
        s1_vld <= 1'b0;
      end

      // S2: load on move; otherwise empties on the output handshake.
      if (s1_move) begin
        s2_data <= s1_res;
        s2_vld  <= 1'b1;
      end else if (out_fire) begin
        s2_vld <= 1'b0;
      end

      // A clear coinciding with a clamped move leaves a count of one, so that
      // event is not lost. The count sticks at all-ones instead of wrapping.
      if (s1_move && s1_sat) begin
        if (cfg_sat_clr) begin
          sat_cnt <= CNT_ONE;
        end else if (sat_cnt != CNT_MAX) begin
          sat_cnt <= sat_cnt + CNT_ONE;
        end
      end else if (cfg_sat_clr) begin
        sat_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sa_sdp_ew_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_sa_sdp_ew_alu_pipe
//
// Directed and randomized bench for sa_sdp_ew_alu_pipe at DATA_WIDTH=16,
// CNT_WIDTH=4. Expected results come from a plain-integer model of the op
// rules evaluated at accept time and kept in an in-order queue; every output
// handshake pops and compares one entry.
// ---------------------------------------------------------------------------
module tb_sa_sdp_ew_alu_pipe;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int CNT_TOP = (1 << CW) - 1;

  localparam logic [1:0] OP_BYP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_MAX = 2'd2;
  localparam logic [1:0] OP_MUL = 2'd3;

  logic          clk;
  logic          rst;
  logic [1:0]    cfg_op;
  logic          cfg_sat_clr;
  logic          in_pvld;
  logic          in_prdy;
  logic [DW-1:0] data1_in;
  logic [DW-1:0] data2_in;
  logic          out_pvld;
  logic          out_prdy;
  logic [DW-1:0] data_out;
  logic [CW-1:0] sat_cnt;
  logic          busy;

  sa_sdp_ew_alu_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .autosa_core_clk (clk),
    .autosa_core_rst (rst),
    .cfg_op          (cfg_op),
    .cfg_sat_clr     (cfg_sat_clr),
    .in_pvld         (in_pvld),
    .in_prdy         (in_prdy),
    .data1_in        (data1_in),
    .data2_in        (data2_in),
    .out_pvld        (out_pvld),
    .out_prdy        (out_prdy),
    .data_out        (data_out),
    .sat_cnt         (sat_cnt),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            n_out    = 0;
  int            model_sat = 0;
  logic [DW-1:0] exp_q[$];
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Op rules with ordinary integer arithmetic; returns {clamped, result}.
  function automatic logic [DW:0] ref_op(input logic [1:0] op, input int a, input int b);
    longint r;
    logic [63:0] rv;
    case (op)
      OP_BYP:  r = a;
      OP_ADD:  r = longint'(a) + longint'(b);
      OP_MAX:  r = (a >= b) ? a : b;
      default: r = longint'(a) * longint'(b);
    endcase
    if (r > 32767)  return {1'b1, 16'h7fff};
    if (r < -32768) return {1'b1, 16'h8000};
    rv = r;
    return {1'b0, rv[DW-1:0]};
  endfunction

  // One clock: drive inputs, sample handshakes just before the edge, update
  // the scoreboard, then advance to 1 ns past the rising edge.
  task automatic step(input logic pv, input logic [1:0] op, input int a, input int b,
                      input logic opr, input logic clr, output logic acc);
    logic          ofire;
    logic [DW:0]   r;
    logic [DW-1:0] e;
    in_pvld     = pv;
    cfg_op      = op;
    data1_in    = a[DW-1:0];
    data2_in    = b[DW-1:0];
    out_prdy    = opr;
    cfg_sat_clr = clr;
    #1;
    acc   = in_pvld && in_prdy;
    ofire = out_pvld && out_prdy;
    if (hold_pending) begin
      check("hold_vld", 32'(out_pvld), 32'd1);
      check("hold_data", 32'(data_out), 32'(hold_data));
    end
    hold_pending = out_pvld && !out_prdy;
    hold_data    = data_out;
    if (ofire) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("data_out", 32'(data_out), 32'(e));
        n_out++;
      end
    end
    if (acc) begin
      r = ref_op(op, a, b);
      exp_q.push_back(r[DW-1:0]);
      if (r[DW] && model_sat < CNT_TOP) model_sat++;
    end
    @(posedge clk);
    #1;
    cfg_sat_clr = 1'b0;
  endtask

  task automatic idle(input logic opr);
    logic acc;
    step(1'b0, OP_BYP, 0, 0, opr, 1'b0, acc);
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && busy; k++) idle(1'b1);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_pvld = 1'b0;
    out_prdy = 1'b0;
    cfg_sat_clr = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_in_prdy", 32'(in_prdy), 32'd0);
    check("rst_out_pvld", 32'(out_pvld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    model_sat = 0;
  endtask

  // Random operand with a bias toward the clamp edges.
  function automatic int rnd_val();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0:       return 32767;
      1:       return -32768;
      2:       return $urandom_range(0, 2) - 1;
      default: begin
        v = DW'($urandom);
        return int'($signed(v));
      end
    endcase
  endfunction

  initial begin
    logic acc;
    int   accepted;
    int   out_base;
    logic saw_stall;
    logic [1:0] rop;
    int   ra;
    int   rb;

    rst = 1'b1;
    cfg_op = OP_BYP;
    cfg_sat_clr = 1'b0;
    in_pvld = 1'b0;
    out_prdy = 1'b0;
    data1_in = '0;
    data2_in = '0;

    // 1. Reset, single ADD beat, two-cycle latency
    do_reset();
    step(1'b1, OP_ADD, 100, -30, 1'b1, 1'b0, acc);
    check("t1_accept", 32'(acc), 32'd1);
    check("t1_lat1_pvld", 32'(out_pvld), 32'd0);
    idle(1'b1);
    check("t1_lat2_pvld", 32'(out_pvld), 32'd1);
    check("t1_data", 32'(data_out), 32'(16'd70));
    drain();
    check("t1_sat_cnt", 32'(sat_cnt), 32'd0);

    // 2. Clamp high on ADD, clamp low on MUL, MAX with equal operands
    step(1'b1, OP_ADD, 32767, 1, 1'b1, 1'b0, acc);
    step(1'b1, OP_MUL, -300, 200, 1'b1, 1'b0, acc);
    step(1'b1, OP_MAX, -5, -5, 1'b1, 1'b0, acc);
    drain();
    check("t2_n_out", 32'(n_out), 32'd4);
    check("t2_sat_cnt", 32'(sat_cnt), 32'd2);

    // 3. Eight back-to-back beats with downstream stalled for cycles 3..6
    out_base = n_out;
    accepted = 0;
    saw_stall = 1'b0;
    for (int c = 0; c < 40 && accepted < 8; c++) begin
      step(1'b1, OP_ADD, accepted * 1000, accepted, !(c >= 3 && c <= 6), 1'b0, acc);
      if (!acc) saw_stall = 1'b1;
      if (acc) accepted++;
    end
    check("t3_accepted", 32'(accepted), 32'd8);
    check("t3_in_prdy_dropped", 32'(saw_stall), 32'd1);
    drain();
    check("t3_n_out", 32'(n_out - out_base), 32'd8);

    // 4. Sticky saturation counter and clear behaviour
    do_reset();
    accepted = 0;
    for (int c = 0; c < 60 && accepted < 20; c++) begin
      step(1'b1, OP_MUL, 30000, 30000, 1'b1, 1'b0, acc);
      if (acc) accepted++;
    end
    drain();
    check("t4_sat_sticky", 32'(sat_cnt), 32'(CNT_TOP));
    step(1'b1, OP_MUL, 30000, -30000, 1'b1, 1'b0, acc);
    check("t4_clr_accept", 32'(acc), 32'd1);
    idle(1'b0);  // spare cycle with downstream stalled; the beat moves to S2 here
    // The beat moved to S2 on the edge above; redo the sequence with clr on
    // the move edge using a fresh beat.
    drain();
    step(1'b1, OP_MUL, 30000, -30000, 1'b1, 1'b0, acc);
    step(1'b0, OP_BYP, 0, 0, 1'b1, 1'b1, acc);   // clr on the saturating move edge
    check("t4_clr_with_move", 32'(sat_cnt), 32'd1);
    step(1'b0, OP_BYP, 0, 0, 1'b1, 1'b1, acc);   // clr with no move
    check("t4_clr_alone", 32'(sat_cnt), 32'd0);
    model_sat = 0;
    drain();

    // 5. Reset with both stages full and downstream stalled
    accepted = 0;
    for (int c = 0; c < 10 && accepted < 2; c++) begin
      step(1'b1, OP_MUL, 300, 300, 1'b0, 1'b0, acc);
      if (acc) accepted++;
    end
    check("t5_filled", 32'(accepted), 32'd2);
    check("t5_full_in_prdy", 32'(in_prdy), 32'd0);
    check("t5_full_busy", 32'(busy), 32'd1);
    check("t5_pre_sat", 32'(sat_cnt), 32'd1);
    rst = 1'b1;
    in_pvld = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_out_pvld", 32'(out_pvld), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_sat_cnt", 32'(sat_cnt), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    hold_pending = 1'b0;
    model_sat = 0;
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("t5_no_stale", 32'(out_pvld), 32'd0);
    end

    // 6. Random traffic and random ops against the model
    out_base = n_out;
    accepted = 0;
    for (int c = 0; c < 60000 && accepted < 10000; c++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_val();
      rb  = rnd_val();
      step(($urandom_range(0, 3) != 0), rop, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) accepted++;
    end
    check("t6_accepted", 32'(accepted), 32'd10000);
    drain();
    check("t6_n_out", 32'(n_out - out_base), 32'd10000);
    check("t6_sat_cnt", 32'(sat_cnt), 32'(model_sat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
